// File: rtl/prll_bs_pkg.sv
// Shared definitions for the parallel-bus round-robin arbiter: message field
// positions, the default broadcast target and the per-bus FSM state encoding.
package prll_bs_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned ID_W   = 16;
  localparam logic [7:0]  BROADCAST_DEF = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PUSH = 2'd2
  } state_e;

  // Field positions are counted down from the message MSB.
  function automatic int tgt_msb(input int bits);
    return bits - 1;
  endfunction

  function automatic int tgt_lsb(input int bits);
    return bits - 8;
  endfunction

  function automatic int src_msb(input int bits);
    return bits - 9;
  endfunction

  function automatic int src_lsb(input int bits);
    return bits - 16;
  endfunction

  function automatic int id_msb(input int bits);
    return bits - 17;
  endfunction

  function automatic int id_lsb(input int bits);
    return bits - 32;
  endfunction

endpackage

// File: rtl/prll_bs_rr_bus.sv
// One bus of the arbiter: round-robin grant, IDLE->POP->PUSH message FSM and
// routing of the captured message. PRLL_BS_STATS_EN adds a message counter.
module prll_bs_rr_bus
  import prll_bs_pkg::*;
#(
  parameter int         DRVRS     = 4,
  parameter int         BITS      = 32,
  parameter logic [7:0] BROADCAST = BROADCAST_DEF
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic            pndng_i  [DRVRS],
  input  logic [BITS-1:0] d_pop_i  [DRVRS],
  output logic            pop_o    [DRVRS],
  output logic            push_o   [DRVRS],
  output logic [BITS-1:0] d_push_o [DRVRS]
`ifdef PRLL_BS_STATS_EN
  ,
  output logic [15:0]     msg_cnt_o
`endif
);

  localparam int IDXW    = (DRVRS > 1) ? $clog2(DRVRS) : 1;
  localparam int TGT_MSB = tgt_msb(BITS);
  localparam int TGT_LSB = tgt_lsb(BITS);

  state_e          state_q, state_d;
  logic [IDXW-1:0] rr_q, rr_d;
  logic [IDXW-1:0] w_q, w_d;
  logic [BITS-1:0] msg_q, msg_d;
  logic [BITS-1:0] d_push_q, d_push_d;
  logic [DRVRS-1:0] pop_q, pop_d;
  logic [DRVRS-1:0] push_q, push_d;

  logic            found_s;
  logic [IDXW-1:0] grant_s;
  logic [IDXW-1:0] idx_s;
  logic [DRVRS-1:0] mask_s;
  logic [7:0]      tgt_s;

  // Round-robin search: first pending driver after rr, wrapping modulo DRVRS.
  always_comb begin
    found_s = 1'b0;
    grant_s = '0;
    idx_s   = '0;
    for (int k = 1; k <= DRVRS; k++) begin
      idx_s = IDXW'((int'(rr_q) + k) % DRVRS);
      if (!found_s && pndng_i[idx_s]) begin
        found_s = 1'b1;
        grant_s = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Destination mask for the captured message.
  always_comb begin
    tgt_s  = msg_q[TGT_MSB:TGT_LSB];
    mask_s = '0;
    for (int i = 0; i < DRVRS; i++) begin
      if (int'(tgt_s) < DRVRS) begin
        mask_s[i] = (int'(tgt_s) == i);
      end else if (tgt_s == BROADCAST) begin
        mask_s[i] = (IDXW'(i) != w_q);
      end else begin
        mask_s[i] = 1'b0;
      end
    end
  end

  // FSM next state; strobes are computed one state ahead so they come out registered.
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    w_d      = w_q;
    msg_d    = msg_q;
    d_push_d = d_push_q;
    pop_d    = '0;
    push_d   = '0;
    case (state_q)
      IDLE: begin
        if (found_s) begin
          pop_d[grant_s] = 1'b1;
          w_d            = grant_s;
          rr_d           = grant_s;
          msg_d          = d_pop_i[grant_s];
          state_d        = POP;
        end else begin
          state_d = IDLE;
        end
      end
      POP: begin
        push_d   = mask_s;
        d_push_d = msg_q;
        state_d  = PUSH;
      end
      PUSH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; rr resets to the last driver so driver 0 wins first.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q  <= IDLE;
      rr_q     <= IDXW'(DRVRS - 1);
      w_q      <= '0;
      msg_q    <= '0;
      d_push_q <= '0;
      pop_q    <= '0;
      push_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      w_q      <= w_d;
      msg_q    <= msg_d;
      d_push_q <= d_push_d;
      pop_q    <= pop_d;
      push_q   <= push_d;
    end
  end

  // Fan the registered strobes and data out to the per-driver ports.
  always_comb begin
    for (int d = 0; d < DRVRS; d++) begin
      pop_o[d]    = pop_q[d];
      push_o[d]   = push_q[d];
      d_push_o[d] = d_push_q;
    end
  end

`ifdef PRLL_BS_STATS_EN
  logic [15:0] cnt_q;

  // One count per completed message, including broadcast and dropped ones.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      cnt_q <= 16'd0;
    end else if (state_q == PUSH) begin
      cnt_q <= cnt_q + 16'd1;
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign msg_cnt_o = cnt_q;
`endif

endmodule

// File: rtl/prll_bs_rr_arbtr.sv
// Multi-bus round-robin arbiter/router: BUSES independent copies of
// prll_bs_rr_bus. PRLL_BS_STATS_EN adds the per-bus msg_cnt output.
module prll_bs_rr_arbtr
  import prll_bs_pkg::*;
#(
  parameter int         BUSES     = 1,
  parameter int         DRVRS     = 4,
  parameter int         BITS      = 32,
  parameter logic [7:0] BROADCAST = BROADCAST_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pndng  [BUSES][DRVRS],
  input  logic [BITS-1:0] D_pop  [BUSES][DRVRS],
  output logic            pop    [BUSES][DRVRS],
  output logic            push   [BUSES][DRVRS],
  output logic [BITS-1:0] D_push [BUSES][DRVRS]
`ifdef PRLL_BS_STATS_EN
  ,
  output logic [15:0]     msg_cnt [BUSES]
`endif
);

  for (genvar b = 0; b < BUSES; b++) begin : g_bus
    prll_bs_rr_bus #(
      .DRVRS     (DRVRS),
      .BITS      (BITS),
      .BROADCAST (BROADCAST)
    ) u_bus (
      .clk_i    (clk),
      .reset_ni (reset),
      .pndng_i  (pndng[b]),
      .d_pop_i  (D_pop[b]),
      .pop_o    (pop[b]),
      .push_o   (push[b]),
      .d_push_o (D_push[b])
`ifdef PRLL_BS_STATS_EN
      ,
      .msg_cnt_o(msg_cnt[b])
`endif
    );
  end

endmodule

// File: tb/tb_prll_bs_rr_arbtr.sv
// Directed bench for prll_bs_rr_arbtr with two buses of four drivers.
module tb_prll_bs_rr_arbtr;

  localparam int BUSES = 2;
  localparam int DRVRS = 4;
  localparam int BITS  = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            pndng  [BUSES][DRVRS];
  logic [BITS-1:0] D_pop  [BUSES][DRVRS];
  logic            pop    [BUSES][DRVRS];
  logic            push   [BUSES][DRVRS];
  logic [BITS-1:0] D_push [BUSES][DRVRS];
`ifdef PRLL_BS_STATS_EN
  logic [15:0]     msg_cnt [BUSES];
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int pops_seen [BUSES][DRVRS];

  prll_bs_rr_arbtr #(
    .BUSES     (BUSES),
    .DRVRS     (DRVRS),
    .BITS      (BITS),
    .BROADCAST (8'hFF)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .pndng  (pndng),
    .D_pop  (D_pop),
    .pop    (pop),
    .push   (push),
    .D_push (D_push)
`ifdef PRLL_BS_STATS_EN
    ,
    .msg_cnt(msg_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] pop_v(input int b);
    logic [3:0] r;
    for (int d = 0; d < DRVRS; d++) r[d] = pop[b][d];
    return r;
  endfunction

  function automatic logic [3:0] push_v(input int b);
    logic [3:0] r;
    for (int d = 0; d < DRVRS; d++) r[d] = push[b][d];
    return r;
  endfunction

  function automatic logic [31:0] mk(input logic [7:0] t, input logic [7:0] s, input logic [15:0] id);
    return {t, s, id};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    for (int b = 0; b < BUSES; b++) begin
      for (int d = 0; d < DRVRS; d++) begin
        pndng[b][d] = 1'b0;
        D_pop[b][d] = 32'd0;
      end
    end
  endtask

  task automatic check_dpush(input string tag, input int b, input logic [31:0] exp);
    for (int d = 0; d < DRVRS; d++) check(tag, 64'(D_push[b][d]), 64'(exp));
  endtask

  initial begin
    reset = 1'b0;
    clear_in();
    tick();
    tick();
    for (int b = 0; b < BUSES; b++) begin
      check("rst_pop", 64'(pop_v(b)), 64'd0);
      check("rst_push", 64'(push_v(b)), 64'd0);
      check_dpush("rst_dpush", b, 32'd0);
    end
`ifdef PRLL_BS_STATS_EN
    check("rst_cnt", 64'(msg_cnt[0]), 64'd0);
`endif
    reset = 1'b1;

    // Single unicast message from driver 2 to driver 1.
    pndng[0][2] = 1'b1;
    D_pop[0][2] = mk(8'd1, 8'd2, 16'd5);
    tick();
    check("uni_pop", 64'(pop_v(0)), 64'h4);
    check("uni_pop_b1", 64'(pop_v(1)), 64'h0);
    check("uni_push_early", 64'(push_v(0)), 64'h0);
    pndng[0][2] = 1'b0;
    tick();
    check("uni_push", 64'(push_v(0)), 64'h2);
    check("uni_pop_off", 64'(pop_v(0)), 64'h0);
    check("uni_push_b1", 64'(push_v(1)), 64'h0);
    check_dpush("uni_dpush", 0, 32'h0102_0005);
    tick();
    check("uni_idle", 64'({pop_v(0), push_v(0)}), 64'h0);

    // Broadcast from driver 3 reaches every other driver.
    pndng[0][3] = 1'b1;
    D_pop[0][3] = mk(8'hFF, 8'd3, 16'h0011);
    tick();
    check("bc_pop", 64'(pop_v(0)), 64'h8);
    pndng[0][3] = 1'b0;
    tick();
    check("bc_push", 64'(push_v(0)), 64'h7);
    check_dpush("bc_dpush", 0, 32'hFF03_0011);
    tick();

    // Invalid target is popped but not delivered.
    pndng[0][1] = 1'b1;
    D_pop[0][1] = mk(8'd9, 8'd1, 16'h0022);
    tick();
    check("drop_pop", 64'(pop_v(0)), 64'h2);
    pndng[0][1] = 1'b0;
    tick();
    check("drop_push", 64'(push_v(0)), 64'h0);
    check("drop_pop_off", 64'(pop_v(0)), 64'h0);
    tick();

    // rr=1: driver 3 is ahead of driver 0, then driver 0 follows.
    pndng[0][0] = 1'b1;
    D_pop[0][0] = mk(8'd2, 8'd0, 16'h0033);
    pndng[0][3] = 1'b1;
    D_pop[0][3] = mk(8'd0, 8'd3, 16'h0044);
    tick();
    check("rr_pop3", 64'(pop_v(0)), 64'h8);
    pndng[0][3] = 1'b0;
    tick();
    check("rr_push0", 64'(push_v(0)), 64'h1);
    check_dpush("rr_dpush3", 0, 32'h0003_0044);
    tick();
    tick();
    check("rr_pop0", 64'(pop_v(0)), 64'h1);
    pndng[0][0] = 1'b0;
    tick();
    check("rr_push2", 64'(push_v(0)), 64'h4);
    check_dpush("rr_dpush0", 0, 32'h0200_0033);
    tick();
`ifdef PRLL_BS_STATS_EN
    check("cnt_b0", 64'(msg_cnt[0]), 64'd5);
    check("cnt_b1", 64'(msg_cnt[1]), 64'd0);
`endif

    // Reset during POP aborts the message and restarts rr.
    pndng[0][2] = 1'b1;
    D_pop[0][2] = mk(8'd0, 8'd2, 16'h0055);
    tick();
    check("abort_pop", 64'(pop_v(0)), 64'h4);
    reset = 1'b0;
    tick();
    check("abort_pop_off", 64'(pop_v(0)), 64'h0);
    check("abort_push_off", 64'(push_v(0)), 64'h0);
`ifdef PRLL_BS_STATS_EN
    check("abort_cnt", 64'(msg_cnt[0]), 64'd0);
`endif

    // Saturated rotation on both buses at once.
    for (int b = 0; b < BUSES; b++) begin
      for (int d = 0; d < DRVRS; d++) begin
        pndng[b][d]     = 1'b1;
        D_pop[b][d]     = mk(8'((d + 1) % 4), 8'(d), 16'(16'h0100 * b + d));
        pops_seen[b][d] = 0;
      end
    end
    reset = 1'b1;
    for (int m = 0; m < 1024; m++) begin
      tick();
      for (int b = 0; b < BUSES; b++) begin
        check("rot_pop", 64'(pop_v(b)), 64'(4'b0001 << (m % 4)));
        for (int d = 0; d < DRVRS; d++) pops_seen[b][d] += int'(pop[b][d]);
      end
      tick();
      for (int b = 0; b < BUSES; b++) begin
        check("rot_push", 64'(push_v(b)), 64'(4'b0001 << ((m + 1) % 4)));
        check("rot_dpush", 64'(D_push[b][(m + 1) % 4]),
              64'(mk(8'((m + 1) % 4), 8'(m % 4), 16'(16'h0100 * b + (m % 4)))));
      end
      tick();
      for (int b = 0; b < BUSES; b++) begin
        check("rot_gap", 64'({pop_v(b), push_v(b)}), 64'h0);
      end
    end
    for (int b = 0; b < BUSES; b++) begin
      for (int d = 0; d < DRVRS; d++) begin
        check("rot_fair", 64'(pops_seen[b][d]), 64'd256);
      end
    end
`ifdef PRLL_BS_STATS_EN
    check("rot_cnt_b0", 64'(msg_cnt[0]), 64'd1024);
    check("rot_cnt_b1", 64'(msg_cnt[1]), 64'd1024);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
